// File: rtl/sweep_ctrl_if.sv
// Sweep controller bus: sweep request/configuration towards the controller,
// counter drive and status back. The loop request exists only with SWEEP_LOOP_EN.
interface sweep_ctrl_if #(
  parameter int WIDTH   = 9,
  parameter int DWELL_W = 16
);
  logic               start;
  logic               abort;
  logic [WIDTH-1:0]   start_incr;
  logic [WIDTH-1:0]   stop_incr;
  logic [WIDTH-1:0]   step;
  logic [DWELL_W-1:0] dwell;
`ifdef SWEEP_LOOP_EN
  logic               loop;
`endif
  logic               en;
  logic [WIDTH-1:0]   incr;
  logic               busy;
  logic               done;

  modport master (
`ifdef SWEEP_LOOP_EN
    output loop,
`endif
    output start, abort, start_incr, stop_incr, step, dwell,
    input  en, incr, busy, done
  );

  modport slave (
`ifdef SWEEP_LOOP_EN
    input  loop,
`endif
    input  start, abort, start_incr, stop_incr, step, dwell,
    output en, incr, busy, done
  );
endinterface

// File: rtl/sweep_ctrl.sv
// Increment sweep sequencer for a counter: dwells at each increment, then steps
// towards stop_incr. Define SWEEP_LOOP_EN to enable continuous looping sweeps.
//
// state | meaning
// IDLE  | waiting for start, en low, incr held
// DWELL | counting down the dwell timer at the current increment
// STEP  | one cycle deciding the next increment (advance, wrap or finish)
// DONE  | one-cycle done pulse, en low, incr held
module sweep_ctrl #(
  parameter int WIDTH   = 9,
  parameter int DWELL_W = 16
) (
  input  logic        clk,
  input  logic        rst,
  sweep_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DWELL = 2'd1,
    STEP  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [DWELL_W-1:0] DWELL_ONE = DWELL_W'(1);

  state_t             state_q, state_d;
  logic               en_q, en_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   incr_q, incr_d;
  logic [WIDTH-1:0]   start_q, start_d;
  logic [WIDTH-1:0]   stop_q, stop_d;
  logic [WIDTH-1:0]   step_q, step_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [DWELL_W-1:0] timer_q, timer_d;
`ifdef SWEEP_LOOP_EN
  logic               loop_q, loop_d;
`endif

  logic [WIDTH:0]     next_sum;
  logic               advance;
  logic               wrap;
  logic               timer_zero;
  logic [DWELL_W-1:0] load_in;
  logic [DWELL_W-1:0] load_lat;

  // One extra bit so a step past the top of the range cannot wrap back below stop.
  assign next_sum   = {1'b0, incr_q} + {1'b0, step_q};
  assign advance    = (step_q != '0) && (next_sum <= {1'b0, stop_q});
`ifdef SWEEP_LOOP_EN
  assign wrap       = loop_q && (next_sum > {1'b0, stop_q});
`else
  assign wrap       = 1'b0;
`endif
  assign timer_zero = (timer_q == '0);
  // Timer holds remaining dwell cycles minus one; a dwell of 0 behaves as 1.
  assign load_in    = (bus.dwell == '0) ? '0 : bus.dwell - DWELL_ONE;
  assign load_lat   = (dwell_q == '0) ? '0 : dwell_q - DWELL_ONE;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.start) state_d = DWELL;
      end
      DWELL: begin
        if (bus.abort)      state_d = IDLE;
        else if (timer_zero) state_d = STEP;
      end
      STEP: begin
        if (bus.abort)            state_d = IDLE;
        else if (advance || wrap) state_d = DWELL;
        else                      state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs are registered from the next state so they align with the state register.
  always_comb begin
    en_d   = (state_d == DWELL) || (state_d == STEP);
    busy_d = (state_d == DWELL) || (state_d == STEP);
    done_d = (state_d == DONE);
  end

  always_comb begin
    incr_d  = incr_q;
    timer_d = timer_q;
    start_d = start_q;
    stop_d  = stop_q;
    step_d  = step_q;
    dwell_d = dwell_q;
`ifdef SWEEP_LOOP_EN
    loop_d  = loop_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          start_d = bus.start_incr;
          stop_d  = bus.stop_incr;
          step_d  = bus.step;
          dwell_d = bus.dwell;
`ifdef SWEEP_LOOP_EN
          loop_d  = bus.loop;
`endif
          incr_d  = bus.start_incr;
          timer_d = load_in;
        end
      end
      DWELL: begin
        if (!bus.abort && !timer_zero) timer_d = timer_q - DWELL_ONE;
      end
      STEP: begin
        if (!bus.abort) begin
          if (advance) begin
            incr_d  = next_sum[WIDTH-1:0];
            timer_d = load_lat;
          end else if (wrap) begin
            incr_d  = start_q;
            timer_d = load_lat;
          end
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      incr_q  <= '0;
      timer_q <= '0;
      start_q <= '0;
      stop_q  <= '0;
      step_q  <= '0;
      dwell_q <= '0;
`ifdef SWEEP_LOOP_EN
      loop_q  <= 1'b0;
`endif
    end else begin
      en_q    <= en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      incr_q  <= incr_d;
      timer_q <= timer_d;
      start_q <= start_d;
      stop_q  <= stop_d;
      step_q  <= step_d;
      dwell_q <= dwell_d;
`ifdef SWEEP_LOOP_EN
      loop_q  <= loop_d;
`endif
    end
  end

  assign bus.en   = en_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.incr = incr_q;

endmodule

// File: tb/tb_sweep_ctrl.sv
// Self-checking bench for sweep_ctrl: directed and randomized sweeps compared
// cycle by cycle against a trace computed from the sweep rules.
module tb_sweep_ctrl;
  localparam int W  = 9;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sweep_ctrl_if #(.WIDTH(W), .DWELL_W(DW)) bus ();
  sweep_ctrl #(.WIDTH(W), .DWELL_W(DW)) dut (.clk(clk), .rst(rst), .bus(bus));

  int vectors     = 0;
  int miscompares = 0;
  logic [W+2:0] exp_q[$];

  // {en, busy, done, incr}
  function automatic logic [W+2:0] pack(bit e, bit b, bit d, int v);
    logic [W-1:0] iv;
    iv = v[W-1:0];
    return {e, b, d, iv};
  endfunction

  task automatic check(string tag, logic [W+2:0] expv);
    logic [W+2:0] obs;
    obs = {bus.en, bus.busy, bus.done, bus.incr};
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed en/busy/done/incr=%b/%b/%b/%0d expected %b/%b/%b/%0d",
             tag, obs[W+2], obs[W+1], obs[W], obs[W-1:0],
             expv[W+2], expv[W+1], expv[W], expv[W-1:0]);
    end
  endtask

  // Expected per-cycle outputs starting with the first cycle after the start edge.
  task automatic build_trace(int si, int so, int st, int dw, bit lp, int cap);
    int v;
    int eff;
    bit fin;
    exp_q.delete();
    v   = si;
    eff = (dw == 0) ? 1 : dw;
    fin = 1'b0;
    while (!fin && exp_q.size() < cap) begin
      repeat (eff + 1) exp_q.push_back(pack(1, 1, 0, v));
      if (st != 0 && v + st <= so) v = v + st;
      else if (lp && v + st > so)  v = si;
      else                         fin = 1'b1;
    end
    if (fin) begin
      exp_q.push_back(pack(0, 0, 1, v));
      exp_q.push_back(pack(0, 0, 0, v));
    end
  endtask

  task automatic scramble();
    bus.start_incr = W'($urandom);
    bus.stop_incr  = W'($urandom);
    bus.step       = W'($urandom);
    bus.dwell      = DW'($urandom_range(0, 5));
`ifdef SWEEP_LOOP_EN
    bus.loop       = 1'($urandom_range(0, 1));
`endif
  endtask

  task automatic run_sweep(string tag, int si, int so, int st, int dw, bit lp,
                           int cap, int abort_at, bit abort_with_start);
    logic [W+2:0] e;
    build_trace(si, so, st, dw, lp, cap);
    bus.start_incr = si[W-1:0];
    bus.stop_incr  = so[W-1:0];
    bus.step       = st[W-1:0];
    bus.dwell      = dw[DW-1:0];
`ifdef SWEEP_LOOP_EN
    bus.loop       = lp;
`endif
    bus.start = 1'b1;
    bus.abort = abort_with_start;
    @(posedge clk);
    #1;
    bus.abort = 1'b0;
    for (int i = 0; i < exp_q.size(); i++) begin
      e = exp_q[i];
      @(negedge clk);
      check(tag, e);
      if (i == abort_at && e[W+1]) begin
        bus.abort = 1'b1;
        bus.start = 1'b0;
        @(negedge clk);
        check({tag, "_abort"}, pack(0, 0, 0, int'(e[W-1:0])));
        bus.abort = 1'b0;
        return;
      end
      scramble();
      bus.start = e[W+1] ? 1'($urandom_range(0, 1)) : 1'b0;
      bus.abort = e[W] ? 1'($urandom_range(0, 1)) : 1'b0;
    end
    bus.start = 1'b0;
    bus.abort = 1'b0;
  endtask

  initial begin
    int si, so, st, dw, ab;
    rst            = 1'b0;
    bus.start      = 1'b0;
    bus.abort      = 1'b0;
    bus.start_incr = '0;
    bus.stop_incr  = '0;
    bus.step       = '0;
    bus.dwell      = '0;
`ifdef SWEEP_LOOP_EN
    bus.loop       = 1'b0;
`endif
    #12;
    check("reset", pack(0, 0, 0, 0));
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("idle_after_reset", pack(0, 0, 0, 0));

    run_sweep("basic_1to4", 1, 4, 1, 3, 0, 1000, -1, 0);
    run_sweep("no_wrap_top", 500, 511, 20, 2, 0, 1000, -1, 0);
    run_sweep("step_zero_dwell_zero", 7, 9, 0, 0, 0, 1000, -1, 0);
    run_sweep("abort_mid_dwell", 1, 4, 1, 3, 0, 1000, 5, 0);
    run_sweep("start_after_abort", 3, 6, 2, 1, 0, 1000, -1, 1);
    run_sweep("inverted_range", 20, 10, 5, 2, 0, 1000, -1, 0);
    run_sweep("stop_at_max", 505, 511, 3, 1, 0, 1000, -1, 0);

    for (int n = 0; n < 25; n++) begin
      si = $urandom_range(0, 511);
      so = $urandom_range(0, 511);
      st = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(8, 64);
      dw = $urandom_range(0, 4);
      ab = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 40) : -1;
      run_sweep("random", si, so, st, dw, 0, 100000, ab, 0);
    end

`ifdef SWEEP_LOOP_EN
    run_sweep("loop_2to4", 2, 4, 2, 1, 1, 30, 29, 0);
`endif

    bus.start_incr = 9'd2;
    bus.stop_incr  = 9'd4;
    bus.step       = 9'd2;
    bus.dwell      = 16'd1;
`ifdef SWEEP_LOOP_EN
    bus.loop       = 1'b1;
`endif
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("reset_mid_sweep", pack(0, 0, 0, 0));
    @(negedge clk);
    check("reset_held", pack(0, 0, 0, 0));
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("idle_after_mid_reset", pack(0, 0, 0, 0));
    end
    run_sweep("post_reset", 10, 40, 10, 2, 0, 1000, -1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/sweep_ctrl.md
SWEEP_CTRL -- requirements
Module: sweep_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 9, giving the increment width; it matches the counter's incr port.
REQ-002 The block SHALL have parameter DWELL_W, default 16, giving the dwell-timer width.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-005 The block SHALL have port start, input, 1 bit: request a sweep; sampled only in IDLE.
REQ-006 The block SHALL have port abort, input, 1 bit: terminate the sweep immediately.
REQ-007 The block SHALL have ports start_incr and stop_incr, input, WIDTH bits each: the first increment and the upper-limit increment.
REQ-008 The block SHALL have port step, input, WIDTH bits: the amount added to the increment per step.
REQ-009 The block SHALL have port dwell, input, DWELL_W bits: cycles spent at each increment; 0 is treated as 1.
REQ-010 The block SHALL have port loop, input, 1 bit: restart at start_incr instead of finishing; present only with SWEEP_LOOP_EN.
REQ-011 The block SHALL have port en, output, 1 bit: drives the counter enable.
REQ-012 The block SHALL have port incr, output, WIDTH bits: drives the counter increment.
REQ-013 The block SHALL have port busy, output, 1 bit: high in DWELL and STEP.
REQ-014 The block SHALL have port done, output, 1 bit: a one-cycle pulse when a sweep completes normally.

Function
REQ-015 The FSM SHALL have exactly four states: IDLE, DWELL, STEP and DONE.
REQ-016 In IDLE, when start=1, the block SHALL do all of the following on the next edge:
- latch start_incr, stop_incr, step, dwell and loop into internal registers;
- set incr to start_incr;
- set en to 1;
- load the dwell timer;
- enter DWELL.
REQ-017 Input changes after the start cycle SHALL NOT affect a sweep in progress.
REQ-018 DWELL SHALL last exactly max(dwell,1) cycles, with en=1 and incr held, and then enter STEP.
REQ-019 STEP SHALL last one cycle with en=1, and SHALL compute next = incr + step in WIDTH+1 bits so that no overflow wraps.
REQ-020 If next <= stop_incr and step != 0, then on the STEP edge incr SHALL take next and the block SHALL re-enter DWELL with the timer reloaded.
REQ-021 Otherwise (next > stop_incr, or step = 0), the block SHALL enter DONE, or wrap as REQ-031 allows.
REQ-022 In DONE, en SHALL be 0, done SHALL be 1 for exactly one cycle, incr SHALL hold its last value, and the next state SHALL be IDLE.
REQ-023 If start_incr > stop_incr, the block SHALL perform one dwell at start_incr and then DONE.
REQ-024 An abort=1 in DWELL or STEP SHALL, on the next edge, set en to 0, enter IDLE, suppress done and hold incr.
REQ-025 Abort SHALL take priority over every other transition. An abort in IDLE or DONE SHALL have no effect, except that the DONE pulse still completes.
REQ-026 In IDLE, en SHALL be 0 and incr SHALL hold its last value.
REQ-027 A start asserted while busy=1 SHALL be ignored. Start and abort asserted together in IDLE SHALL start the sweep.
REQ-028 All outputs SHALL be registered, with no combinational path from input to output.

Reset
REQ-029 While rst=0, the block SHALL asynchronously force: state IDLE, en=0, incr=0, busy=0, done=0, dwell timer 0, and all latched configuration registers 0.
REQ-030 Reset asserted mid-sweep SHALL abandon the sweep without a done pulse. After rst returns to 1, the block SHALL wait in IDLE for a new start.

Configuration
REQ-031 With SWEEP_LOOP_EN defined, the loop port SHALL exist. When the latched loop=1 and STEP finds next > stop_incr, incr SHALL reload the latched start_incr and the block SHALL re-enter DWELL without a done pulse; the sweep then repeats until abort or reset.
REQ-032 Without SWEEP_LOOP_EN, the loop port and its register SHALL be absent, and every sweep SHALL terminate through DONE.

Verification
REQ-033 start_incr=1, stop_incr=4, step=1, dwell=3 -> incr sequence 1,2,3,4, each held for 3 DWELL cycles plus 1 STEP cycle; done pulses once; en low afterwards.
REQ-034 WIDTH=9, start_incr=500, stop_incr=511, step=20 -> one dwell at 500 with no wrap to 8; done pulses.
REQ-035 Abort on the 2nd DWELL cycle of the 2nd step (incr=2) -> next cycle en=0, state IDLE, incr=2, no done; a start in the following cycle is accepted.
REQ-036 dwell=0 and step=0, start_incr=7 -> one DWELL cycle plus one STEP cycle at incr=7, then done; a start pulsed during busy is ignored.
REQ-037 With SWEEP_LOOP_EN, loop=1, 2->4 step 2, dwell=1 -> incr 2,4,2,4,... with no done until abort; rst driven to 0 mid-sweep -> immediately en=0, incr=0.
